// File: rtl/inst_mem_loader_if.sv
// Loader-side bundle: host byte stream and control in, memory write port and core status out.
interface inst_mem_loader_if #(
    parameter int LEN_W = 16
);
    logic             Load_Start;
    logic [LEN_W-1:0] Load_Length;
    logic [7:0]       In_Byte;
    logic             In_Valid;
    logic             In_Ready;
    logic             Wr_En;
    logic [63:0]      Wr_Address;
    logic [7:0]       Wr_Data;
    logic             Core_Hold;
    logic             Load_Done;
    logic             Load_Err;
    logic [LEN_W-1:0] Bytes_Loaded;

    // Host / byte-source view.
    modport master (
        output Load_Start, Load_Length, In_Byte, In_Valid,
        input  In_Ready, Wr_En, Wr_Address, Wr_Data, Core_Hold, Load_Done, Load_Err, Bytes_Loaded
    );

    // Loader view.
    modport slave (
        input  Load_Start, Load_Length, In_Byte, In_Valid,
        output In_Ready, Wr_En, Wr_Address, Wr_Data, Core_Hold, Load_Done, Load_Err, Bytes_Loaded
    );
endinterface

// File: rtl/inst_mem_loader.sv
// Streams a byte image into instruction memory from address 0 and holds the core until it is complete.
// Optional INST_LOADER_CHECKSUM_EN: a trailing checksum byte must bring the image sum to zero.
module inst_mem_loader #(
    parameter int MEM_BYTES = 256,
    parameter int LEN_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    inst_mem_loader_if.slave bus
);
    localparam logic [1:0]       ST_IDLE  = 2'd0;
    localparam logic [1:0]       ST_LOAD  = 2'd1;
    localparam logic [1:0]       ST_DONE  = 2'd2;
    localparam logic [LEN_W-1:0] LEN_ZERO = {LEN_W{1'b0}};
    localparam logic [LEN_W-1:0] LEN_ONE  = {{(LEN_W-1){1'b0}}, 1'b1};
    localparam logic [LEN_W-1:0] LEN_MAX  = LEN_W'(MEM_BYTES);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [LEN_W-1:0] len_r;
    logic [LEN_W-1:0] count_r;
    logic [LEN_W-1:0] bytes_loaded_r;
    logic             wr_en_r;
    logic [63:0]      wr_addr_r;
    logic [7:0]       wr_data_r;
    logic             core_hold_r;
    logic             load_done_r;
    logic             load_err_r;

    logic             in_ready_s;
    logic             hs_s;
    logic             img_hs_s;
    logic             final_hs_s;
    logic             start_ok_s;
    logic             start_rej_s;
    logic             pass_s;

    // Whole 32-bit words only, non-empty, and it must fit in memory.
    function automatic logic len_legal(input logic [LEN_W-1:0] len);
        return (len != LEN_ZERO) && (len <= LEN_MAX) && (len[1:0] == 2'b00);
    endfunction

`ifdef INST_LOADER_CHECKSUM_EN
    logic [7:0] sum_r;

    function automatic logic [7:0] csum_add(input logic [7:0] acc, input logic [7:0] b);
        return acc + b;
    endfunction
`endif

    // Handshake decode, start qualification and next-state selection.
    always_comb begin
        in_ready_s = (state_r == ST_LOAD);
        hs_s       = bus.In_Valid & in_ready_s;
        if ((state_r == ST_IDLE) && bus.Load_Start) begin
            start_ok_s  = len_legal(bus.Load_Length);
            start_rej_s = ~start_ok_s;
        end else begin
            start_ok_s  = 1'b0;
            start_rej_s = 1'b0;
        end
`ifdef INST_LOADER_CHECKSUM_EN
        // Once count reaches the length, the next handshake is the checksum byte.
        img_hs_s   = hs_s & (count_r != len_r);
        final_hs_s = hs_s & (count_r == len_r);
        pass_s     = (csum_add(sum_r, bus.In_Byte) == 8'h00);
`else
        img_hs_s   = hs_s;
        final_hs_s = hs_s & (count_r == (len_r - LEN_ONE));
        pass_s     = 1'b1;
`endif
        case (state_r)
            ST_IDLE: begin
                if (start_ok_s) begin
                    state_nxt_s = ST_LOAD;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_LOAD: begin
                if (final_hs_s) begin
                    state_nxt_s = ST_DONE;
                end else begin
                    state_nxt_s = ST_LOAD;
                end
            end
            ST_DONE: state_nxt_s = ST_IDLE;
            default: state_nxt_s = ST_IDLE;
        endcase
    end

    // Control state: FSM, status pulses and core hold.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            core_hold_r <= 1'b1;
            load_done_r <= 1'b0;
            load_err_r  <= 1'b0;
        end else begin
            state_r     <= state_nxt_s;
            load_done_r <= final_hs_s & pass_s;
            load_err_r  <= start_rej_s | (final_hs_s & ~pass_s);
            if (start_ok_s) begin
                core_hold_r <= 1'b1;
            end else if (state_r == ST_DONE) begin
                // Release only when this DONE cycle reports success.
                core_hold_r <= ~load_done_r;
            end else begin
                core_hold_r <= core_hold_r;
            end
        end
    end

    // Datapath: length latch, byte counter and the registered write port.
    always_ff @(posedge clk) begin
        if (reset) begin
            len_r          <= LEN_ZERO;
            count_r        <= LEN_ZERO;
            bytes_loaded_r <= LEN_ZERO;
            wr_en_r        <= 1'b0;
            wr_addr_r      <= 64'h0;
            wr_data_r      <= 8'h00;
        end else begin
            wr_en_r <= img_hs_s;
            if (start_ok_s) begin
                len_r          <= bus.Load_Length;
                count_r        <= LEN_ZERO;
                bytes_loaded_r <= LEN_ZERO;
            end else if (img_hs_s) begin
                wr_addr_r      <= 64'(count_r);
                wr_data_r      <= bus.In_Byte;
                count_r        <= count_r + LEN_ONE;
                bytes_loaded_r <= bytes_loaded_r + LEN_ONE;
            end else begin
                count_r        <= count_r;
            end
        end
    end

`ifdef INST_LOADER_CHECKSUM_EN
    // Running 8-bit sum of the image bytes.
    always_ff @(posedge clk) begin
        if (reset) begin
            sum_r <= 8'h00;
        end else if (start_ok_s) begin
            sum_r <= 8'h00;
        end else if (img_hs_s) begin
            sum_r <= csum_add(sum_r, bus.In_Byte);
        end else begin
            sum_r <= sum_r;
        end
    end
`endif

    assign bus.In_Ready     = in_ready_s;
    assign bus.Wr_En        = wr_en_r;
    assign bus.Wr_Address   = wr_addr_r;
    assign bus.Wr_Data      = wr_data_r;
    assign bus.Core_Hold    = core_hold_r;
    assign bus.Load_Done    = load_done_r;
    assign bus.Load_Err     = load_err_r;
    assign bus.Bytes_Loaded = bytes_loaded_r;

endmodule

// File: tb/tb_inst_mem_loader.sv
// Table-driven bench for inst_mem_loader plus a hand-written full-capacity load with bubbles.
module tb_inst_mem_loader;
    localparam int MEM_BYTES = 256;
    localparam int LEN_W     = 16;
`ifdef INST_LOADER_CHECKSUM_EN
    localparam int CK = 1;
`else
    localparam int CK = 0;
`endif

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    inst_mem_loader_if #(.LEN_W(LEN_W)) bus ();

    inst_mem_loader #(.MEM_BYTES(MEM_BYTES), .LEN_W(LEN_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    typedef struct {
        logic [63:0] tag;
        logic        rst;
        logic        start;
        logic [15:0] len;
        logic        valid;
        logic [7:0]  din;
        logic        e_rdy;
        logic        e_we;
        logic        chk_ad;
        logic [63:0] e_addr;
        logic [7:0]  e_data;
        logic        e_hold;
        logic        e_done;
        logic        e_err;
        logic [15:0] e_bl;
    } vec_t;

    vec_t        vecs[$];
    logic [7:0]  img[$];
    int          n_vec = 0;
    int          n_miss = 0;
    int          cur_k = 0;
    logic [63:0] cur_tag = 64'h0;
    logic        m_hold;
    logic [15:0] m_bl;

    task automatic chk(input string what, input logic [63:0] act, input logic [63:0] exp);
        if (act !== exp) begin
            n_miss++;
            $display("FAIL vec %0d %s %s: actual %0h required %0h", cur_k, cur_tag, what, act, exp);
        end
    endtask

    task automatic push(input logic [63:0] tag, input logic rst, input logic start, input logic [15:0] len,
                        input logic valid, input logic [7:0] din, input logic e_rdy, input logic e_we,
                        input logic chk_ad, input logic [63:0] e_addr, input logic [7:0] e_data,
                        input logic e_hold, input logic e_done, input logic e_err, input logic [15:0] e_bl);
        vec_t v;
        v.tag = tag; v.rst = rst; v.start = start; v.len = len; v.valid = valid; v.din = din;
        v.e_rdy = e_rdy; v.e_we = e_we; v.chk_ad = chk_ad; v.e_addr = e_addr; v.e_data = e_data;
        v.e_hold = e_hold; v.e_done = e_done; v.e_err = e_err; v.e_bl = e_bl;
        vecs.push_back(v);
    endtask

    task automatic idle_vec(input logic [63:0] tag, input logic chk_ad, input logic [7:0] din);
        push(tag, 1'b0, 1'b0, 16'd0, 1'b0, din, 1'b0, 1'b0, chk_ad, 64'd0, 8'h00, m_hold, 1'b0, 1'b0, m_bl);
    endtask

    task automatic set_img(input logic [63:0] bytes, input int n);
        img.delete();
        for (int i = 0; i < n; i++) img.push_back(bytes[63-8*i -: 8]);
    endtask

    // Expected vectors for a load of img; stops early (no done) when n_send < image size.
    task automatic load_seq(input logic [63:0] tag, input int n_send, input logic gap, input logic [7:0] ck_delta);
        int         len;
        logic       last;
        logic       pass;
        logic [7:0] sum;
        logic [7:0] ck;
        len = img.size();
        sum = 8'h00;
        push(tag, 1'b0, 1'b1, 16'(len), 1'b0, 8'h00, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        m_hold = 1'b1;
        m_bl   = 16'd0;
        for (int i = 0; i < n_send; i++) begin
            last = (i == len - 1);
            if (gap) begin
                push(tag, 1'b0, (i == 1), 16'd0, 1'b0, 8'hFF, 1'b1, 1'b0, 1'b0, 64'd0, 8'h00,
                     1'b1, 1'b0, 1'b0, m_bl);
            end
            m_bl = m_bl + 16'd1;
            sum  = sum + img[i];
            push(tag, 1'b0, 1'b0, 16'd0, 1'b1, img[i], (!last || (CK != 0)), 1'b1, 1'b1, 64'(i), img[i],
                 1'b1, (last && (CK == 0)), 1'b0, m_bl);
        end
        ck   = 8'h00 - sum + ck_delta;
        pass = (ck_delta == 8'h00);
        if (n_send == len) begin
`ifdef INST_LOADER_CHECKSUM_EN
            push(tag, 1'b0, 1'b0, 16'd0, 1'b1, ck, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b1, pass, !pass, m_bl);
            m_hold = !pass;
`else
            m_hold = 1'b0;
`endif
            idle_vec(tag, 1'b0, ck);
        end
    endtask

    task automatic reject_vec(input logic [63:0] tag, input logic [15:0] len);
        push(tag, 1'b0, 1'b1, len, 1'b1, 8'h55, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00, m_hold, 1'b0, 1'b1, m_bl);
        idle_vec(tag, 1'b0, 8'h00);
    endtask

    // Full-capacity load with a bubble every third cycle, checked cycle by cycle.
    task automatic full_load();
        int         sent;
        int         cyc;
        int         total;
        logic       hs;
        logic       wr;
        logic       done_seen;
        logic [7:0] sum;
        logic [7:0] b;
        total     = MEM_BYTES + CK;
        sent      = 0;
        cyc       = 0;
        sum       = 8'h00;
        done_seen = 1'b0;
        cur_tag   = "full";
        @(negedge clk);
        bus.Load_Start  = 1'b1;
        bus.Load_Length = 16'(MEM_BYTES);
        bus.In_Valid    = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        chk("full_start_rdy", bus.In_Ready, 64'd1);
        chk("full_start_hold", bus.Core_Hold, 64'd1);
        chk("full_start_bl", bus.Bytes_Loaded, 64'd0);
        while (!done_seen && cyc < 4 * total) begin
            @(negedge clk);
            bus.Load_Start = 1'b0;
            bus.In_Valid   = (sent < total) && ((cyc % 3) != 2);
            b              = (sent < MEM_BYTES) ? 8'(sent * 7 + 3) : (8'h00 - sum);
            bus.In_Byte    = b;
            #1 hs = bus.In_Valid & bus.In_Ready;
            @(posedge clk); #1;
            n_vec++;
            wr = hs && (sent < MEM_BYTES);
            chk("full_we", bus.Wr_En, 64'(wr));
            if (wr) begin
                chk("full_addr", bus.Wr_Address, 64'(sent));
                chk("full_data", bus.Wr_Data, 64'(b));
                sum = sum + b;
            end
            if (hs) sent++;
            chk("full_done", bus.Load_Done, 64'(hs && (sent == total)));
            chk("full_err", bus.Load_Err, 64'd0);
            chk("full_hold", bus.Core_Hold, 64'd1);
            if (bus.Load_Done) done_seen = 1'b1;
            cyc++;
        end
        n_vec++;
        chk("full_finished", 64'(done_seen), 64'd1);
        chk("full_count", bus.Bytes_Loaded, 64'(MEM_BYTES));
        @(negedge clk);
        bus.In_Valid = 1'b0;
        @(posedge clk); #1;
        n_vec++;
        chk("full_release", bus.Core_Hold, 64'd0);
        chk("full_idle_we", bus.Wr_En, 64'd0);
        chk("full_idle_rdy", bus.In_Ready, 64'd0);
    endtask

    initial begin
        reset           = 1'b1;
        bus.Load_Start  = 1'b0;
        bus.Load_Length = 16'd0;
        bus.In_Byte     = 8'h00;
        bus.In_Valid    = 1'b0;
        m_hold          = 1'b1;
        m_bl            = 16'd0;

        for (int i = 0; i < 2; i++)
            push("reset", 1'b1, 1'b0, 16'd0, 1'b0, 8'h00, 1'b0, 1'b0, 1'b1, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        for (int i = 0; i < 5; i++) idle_vec("idle", 1'b1, 8'h00);
        set_img(64'h9305600093_0E6000, 8);
        load_seq("nogap", 8, 1'b0, 8'h00);
        load_seq("gaps", 8, 1'b1, 8'h00);
        reject_vec("rej6", 16'd6);
        reject_vec("rej0", 16'd0);
        reject_vec("rejbig", 16'(MEM_BYTES + 4));
        load_seq("rstmid", 3, 1'b0, 8'h00);
        push("rstmid", 1'b1, 1'b0, 16'd0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b1, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        m_hold = 1'b1;
        m_bl   = 16'd0;
        push("rstmid", 1'b0, 1'b0, 16'd0, 1'b1, 8'hAA, 1'b0, 1'b0, 1'b0, 64'd0, 8'h00, 1'b1, 1'b0, 1'b0, 16'd0);
        set_img(64'h130F0000_00000000, 4);
        load_seq("len4", 4, 1'b0, 8'h00);
`ifdef INST_LOADER_CHECKSUM_EN
        load_seq("ckbad", 4, 1'b0, 8'h01);
        load_seq("ckgood", 4, 1'b1, 8'h00);
`endif

        foreach (vecs[k]) begin
            @(negedge clk);
            reset           = vecs[k].rst;
            bus.Load_Start  = vecs[k].start;
            bus.Load_Length = vecs[k].len;
            bus.In_Valid    = vecs[k].valid;
            bus.In_Byte     = vecs[k].din;
            @(posedge clk); #1;
            n_vec++;
            cur_k   = k;
            cur_tag = vecs[k].tag;
            chk("In_Ready", bus.In_Ready, 64'(vecs[k].e_rdy));
            chk("Wr_En", bus.Wr_En, 64'(vecs[k].e_we));
            if (vecs[k].chk_ad) begin
                chk("Wr_Address", bus.Wr_Address, vecs[k].e_addr);
                chk("Wr_Data", bus.Wr_Data, 64'(vecs[k].e_data));
            end
            chk("Core_Hold", bus.Core_Hold, 64'(vecs[k].e_hold));
            chk("Load_Done", bus.Load_Done, 64'(vecs[k].e_done));
            chk("Load_Err", bus.Load_Err, 64'(vecs[k].e_err));
            chk("Bytes_Loaded", bus.Bytes_Loaded, 64'(vecs[k].e_bl));
        end

        cur_k = vecs.size();
        full_load();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
